// File: rtl/cluster_input_assembler.sv
// Collects a frame of IN_W-bit words into one VEC_W-bit vector for the output-bit cluster.
// Framing errors resync on in_last. A completed frame waits in HOLD while the output slot is busy.
module cluster_input_assembler #(
  parameter int IN_W  = 32,
  parameter int VEC_W = 1894
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [VEC_W-1:0] i_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  localparam int NWORDS = (VEC_W + IN_W - 1) / IN_W;
  localparam int LAST_W = VEC_W - (NWORDS - 1) * IN_W;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  localparam logic [1:0] ST_ASM  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] wcnt_reg, wcnt_next;
  logic [VEC_W-1:0] i_vec_reg;
  logic             out_valid_reg;
  logic             frame_err_reg, err_next;
  logic [15:0]      frame_cnt_reg;
  logic             load_new, load_held;

  logic             accept, at_last, slot_free, word_we;
  logic [VEC_W-1:0] asm_vec;
  logic [VEC_W-1:0] frame_vec;

  assign in_ready  = (state_reg != ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign at_last   = (wcnt_reg == LAST_IDX);
  assign slot_free = !out_valid_reg || out_ready;
  assign word_we   = accept && (state_reg == ST_ASM);

  // One register per word slot; the last slot keeps only its valid low bits.
  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_word
      localparam int W = (gi == NWORDS - 1) ? LAST_W : IN_W;
      logic [W-1:0] word_reg;
      always_ff @(posedge clk) begin
        if (word_we && (wcnt_reg == CNT_W'(gi)))
          word_reg <= in_data[W-1:0];
      end
      assign asm_vec[gi*IN_W +: W] = word_reg;
    end
  endgenerate

  // The final word is still on in_data when the frame completes, so bypass its slot.
  assign frame_vec = {in_data[LAST_W-1:0], asm_vec[VEC_W-LAST_W-1:0]};

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    err_next   = 1'b0;
    load_new   = 1'b0;
    load_held  = 1'b0;
    case (state_reg)
      ST_ASM: begin
        if (accept) begin
          if (in_last) begin
            wcnt_next = '0;
            if (at_last) begin
              if (slot_free) load_new   = 1'b1;
              else           state_next = ST_HOLD;
            end else begin
              err_next = 1'b1;
            end
          end else if (at_last) begin
            err_next   = 1'b1;
            wcnt_next  = '0;
            state_next = ST_DROP;
          end else begin
            wcnt_next = wcnt_reg + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          load_held  = 1'b1;
          state_next = ST_ASM;
        end
      end
      ST_DROP: begin
        if (accept && in_last) begin
          state_next = ST_ASM;
          wcnt_next  = '0;
        end
      end
      default: begin
        state_next = ST_ASM;
        wcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_ASM;
      wcnt_reg      <= '0;
      i_vec_reg     <= '0;
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      frame_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      wcnt_reg      <= wcnt_next;
      frame_err_reg <= err_next;
      if (load_new) begin
        i_vec_reg     <= frame_vec;
        out_valid_reg <= 1'b1;
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end else if (load_held) begin
        i_vec_reg     <= asm_vec;
        out_valid_reg <= 1'b1;
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign i_vec     = i_vec_reg;
  assign out_valid = out_valid_reg;
  assign frame_err = frame_err_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_cluster_input_assembler.sv
// Scoreboard bench for cluster_input_assembler: directed framing cases, then randomly throttled frames.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_cluster_input_assembler;

  localparam int IN_W  = 32;
  localparam int VEC_W = 1894;
  localparam int NW    = (VEC_W + IN_W - 1) / IN_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [VEC_W-1:0] i_vec;
  logic             out_valid;
  logic             out_ready;
  logic             frame_err;
  logic [15:0]      frame_cnt;

  cluster_input_assembler #(.IN_W(IN_W), .VEC_W(VEC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .i_vec     (i_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int err_seen  = 0;
  int err_exp   = 0;
  int deliver_idx = 0;
  int good_sent = 0;
  bit rnd_ready = 1'b0;
  bit fixed_ready = 1'b1;
  logic [VEC_W-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end else begin
      $display("check %s ok value=%0h", nm, got);
    end
  endtask

  // Single driver for out_ready: directed value or random throttling.
  always begin
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? ($urandom_range(0, 7) != 0) : fixed_ready;
  end

  // Monitor: whenever a frame is presented it must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_err) err_seen++;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame got out_valid=1 expected out_valid=0 cnt=%0d", frame_cnt);
        end else begin
          logic [NW*IN_W-1:0] a, e;
          a = {{(NW*IN_W-VEC_W){1'b0}}, i_vec};
          e = {{(NW*IN_W-VEC_W){1'b0}}, exp_q[0]};
          if (a !== e) begin
            failures++;
            for (int k = 0; k < NW; k++) begin
              if (a[k*IN_W +: IN_W] !== e[k*IN_W +: IN_W]) begin
                $display("FAIL i_vec frame=%0d word=%0d got=%h expected=%h",
                         deliver_idx, k, a[k*IN_W +: IN_W], e[k*IN_W +: IN_W]);
                break;
              end
            end
          end
          checks++;
          if (frame_cnt !== 16'(deliver_idx + 1)) begin
            failures++;
            $display("FAIL frame_cnt got=%0d expected=%0d", frame_cnt, 16'(deliver_idx + 1));
          end
          if (out_ready) begin
            $display("frame %0d delivered frame_cnt=%0d", deliver_idx, frame_cnt);
            void'(exp_q.pop_front());
            deliver_idx++;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [IN_W-1:0] d, input logic l);
    bit r;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout got in_ready=0 expected in_ready=1 within 2000 cycles");
    end
  endtask

  function automatic logic [NW*IN_W-1:0] make_frame(input bit pattern);
    logic [NW*IN_W-1:0] f;
    for (int k = 0; k < NW; k++)
      f[k*IN_W +: IN_W] = pattern ? ((k == NW-1) ? 32'hFFFF_FFC5 : IN_W'(k)) : IN_W'($urandom);
    return f;
  endfunction

  task automatic send_good(input int gap_pct);
    logic [NW*IN_W-1:0] f;
    f = make_frame(1'b0);
    exp_q.push_back(f[VEC_W-1:0]);
    good_sent++;
    for (int k = 0; k < NW; k++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
      send_word(f[k*IN_W +: IN_W], k == NW-1);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_short(input int n);
    for (int k = 0; k < n; k++) send_word(IN_W'($urandom), k == n-1);
    in_valid = 1'b0;
    err_exp++;
  endtask

  task automatic send_long(input int extra);
    for (int k = 0; k < NW + extra; k++) send_word(IN_W'($urandom), k == NW + extra - 1);
    in_valid = 1'b0;
    err_exp++;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_in_time", 64'(n < 5000), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish expected finish before 2000000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW*IN_W-1:0] f;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("reset_frame_err", 64'(frame_err), 64'd0);
    chk("reset_in_ready",  64'(in_ready), 64'd1);
    chk("reset_i_vec_zero", 64'(i_vec == '0), 64'd1);

    // Known pattern, back-to-back, free output slot.
    fixed_ready = 1'b1;
    idle(2);
    f = make_frame(1'b1);
    exp_q.push_back(f[VEC_W-1:0]);
    good_sent++;
    for (int k = 0; k < NW-1; k++) send_word(f[k*IN_W +: IN_W], 1'b0);
    chk("pattern_no_early_valid", 64'(out_valid), 64'd0);
    send_word(f[(NW-1)*IN_W +: IN_W], 1'b1);
    chk("pattern_valid_next_cycle", 64'(out_valid), 64'd1);
    chk("pattern_word0", 64'(i_vec[31:0]), 64'd0);
    chk("pattern_word1", 64'(i_vec[63:32]), 64'd1);
    chk("pattern_last_bits", 64'(i_vec[1893:1888]), 64'b000101);
    chk("pattern_frame_cnt", 64'(frame_cnt), 64'd1);
    in_valid = 1'b0;
    drain();

    // Two frames with the output blocked: second frame parks in HOLD.
    fixed_ready = 1'b0;
    idle(2);
    send_good(0);
    send_good(0);
    chk("hold_in_ready_low", 64'(in_ready), 64'd0);
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    idle(3);
    fixed_ready = 1'b1;
    drain();
    chk("hold_frame_cnt", 64'(frame_cnt), 64'(good_sent));

    // Short frame: in_last on word 10.
    send_short(11);
    chk("short_err_pulse", 64'(frame_err), 64'd1);
    idle(1);
    chk("short_err_one_cycle", 64'(frame_err), 64'd0);
    send_good(0);
    drain();

    // Long frame: 60 words without in_last, then 3 more ending with in_last.
    send_long(3);
    idle(1);
    send_good(0);
    drain();

    // Reset part way through a frame.
    for (int k = 0; k < 31; k++) send_word(IN_W'($urandom), 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    deliver_idx = 0;
    good_sent = 0;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("midreset_frame_err", 64'(frame_err), 64'd0);
    chk("midreset_in_ready",  64'(in_ready), 64'd1);
    chk("midreset_i_vec_zero", 64'(i_vec == '0), 64'd1);
    send_good(0);
    drain();
    chk("midreset_frame_cnt_after", 64'(frame_cnt), 64'd1);

    // Random throttling on both sides with occasional framing errors.
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)      send_short($urandom_range(1, NW-1));
      else if (r < 3) send_long($urandom_range(1, 4));
      else            send_good(6);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
    end
    drain();
    chk("random_frame_cnt", 64'(frame_cnt), 64'(16'(good_sent)));
    chk("frame_err_count", 64'(err_seen), 64'(err_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cluster_input_assembler.md
CLUSTER_INPUT_ASSEMBLER -- requirements
Module: cluster_input_assembler

Interface
REQ-001 SHALL have parameter IN_W, default 32, input word width in bits.
REQ-002 SHALL have parameter VEC_W, default 1894, assembled input-vector width presented to the output-bit cluster.
REQ-003 SHALL derive localparam NWORDS = ceil(VEC_W/IN_W), which is 60 at defaults; the last word carries VEC_W-(NWORDS-1)*IN_W valid bits, which is 6 at defaults.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port in_data, input, IN_W, input word.
REQ-007 SHALL have port in_valid, input, 1, in_data/in_last valid.
REQ-008 SHALL have port in_last, input, 1, marks final word of a frame.
REQ-009 SHALL have port in_ready, output, 1, assembler accepts a word this cycle.
REQ-010 SHALL have port i_vec, output, VEC_W, assembled vector driving the cluster input bus.
REQ-011 SHALL have port out_valid, output, 1, i_vec holds a complete frame.
REQ-012 SHALL have port out_ready, input, 1, downstream sampling stage consumes i_vec.
REQ-013 SHALL have port frame_err, output, 1, one-cycle pulse on framing error.
REQ-014 SHALL have port frame_cnt, output, 16, count of frames delivered, wrapping.

Function
REQ-015 SHALL accept a word only when in_valid && in_ready (the "accept" event).
REQ-016 SHALL write accepted word k (k = 0..NWORDS-1) into assembly bits [k*IN_W +: IN_W]; for word NWORDS-1, only the low valid bits are used and the upper bits are ignored.
REQ-017 SHALL keep a word counter wcnt, 0..NWORDS-1, that increments on each accept and returns to 0 after the final word or after any error.
REQ-018 SHALL implement states ASM (collecting), HOLD (frame complete, output slot busy) and DROP (resynchronising).
REQ-019 SHALL, when word NWORDS-1 is accepted with in_last=1, complete the frame. If out_valid=0, or out_valid && out_ready that cycle, it copies the frame into i_vec and asserts out_valid on the next cycle. Otherwise it enters HOLD.
REQ-020 SHALL drive in_ready=0 in HOLD; in HOLD, when out_ready=1, it transfers the frame to i_vec, keeps out_valid=1 and returns to ASM on the next cycle.
REQ-021 SHALL deassert out_valid the cycle after out_valid && out_ready, unless a new frame is transferred in that same cycle.
REQ-022 SHALL hold i_vec stable while out_valid=1 and out_ready=0.
REQ-023 SHALL handle an accept with in_last=1 and wcnt<NWORDS-1 (short frame) as follows: pulse frame_err, discard the partial frame, set wcnt=0 and stay in ASM.
REQ-024 SHALL handle an accept of word NWORDS-1 with in_last=0 (long frame) as follows: pulse frame_err, discard the frame and enter DROP.
REQ-025 SHALL, in DROP, keep in_ready=1, discard every word, and return to ASM (wcnt=0) after the accept that carries in_last=1.
REQ-026 SHALL increment frame_cnt by 1 (mod 2^16) on each transfer into i_vec, never on errors.
REQ-027 SHALL give first-word-to-out_valid latency of NWORDS cycles with back-to-back in_valid and a free output slot: out_valid rises the cycle after the final accept.
REQ-028 SHALL sustain one frame per NWORDS cycles when out_ready=1 continuously, with no bubble inserted.
REQ-029 SHALL drive in_ready=1 in ASM and DROP.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, set state=ASM, wcnt=0, out_valid=0, i_vec=0, frame_err=0 and frame_cnt=0; in_ready reads 1 from the first cycle after reset.
REQ-031 SHALL, on reset mid-frame or in HOLD, abandon the partial or held frame without a frame_err pulse.

Verification
REQ-032 SHALL cover: 60 back-to-back words, word k = k, last word 0xFFFFFFC5, in_last on word 59, out_ready=1 -> out_valid rises the cycle after the word-59 accept; i_vec[31:0]=0, i_vec[63:32]=1, i_vec[1893:1888]=6'b000101; frame_cnt=1.
REQ-033 SHALL cover: two frames back-to-back with out_ready=0 -> first frame held, in_ready=0 after the second frame completes (HOLD); raise out_ready -> frame A then frame B delivered, frame_cnt=2, no words lost.
REQ-034 SHALL cover: in_last on word 10 -> frame_err pulses one cycle, out_valid stays 0, the next 60-word frame is delivered correctly.
REQ-035 SHALL cover: 60 words without in_last followed by 3 words with in_last on the third -> frame_err pulse, all 63 words discarded, the next frame is delivered correctly.
REQ-036 SHALL cover: rst_n=0 for one cycle after word 30 -> all outputs at reset values, a fresh 60-word frame is delivered, frame_cnt=1.
REQ-037 SHALL cover: random in_valid/out_ready throttling over 1000 frames -> the scoreboard matches every i_vec and frame_cnt equals the number of frames sent.
